axi_lite_sram: RTL

//  AXI4-Lite slave memory sitting directly downstream of the LSU AXI master.

---
 rtl/axi_lite_sram.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_sram.sv
// ============================================================================
// Module   : axi_lite_sram
// Purpose  : AXI4-Lite slave word memory, one transaction at a time, fixed
//            response latency, SLVERR outside [BASE, BASE + 4*2^ADDR_WIDTH).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_sram #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter int          LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready
);

    localparam logic [2:0]  c_IDLE    = 3'd0;
    localparam logic [2:0]  c_WR_WAIT = 3'd1;
    localparam logic [2:0]  c_WR_RESP = 3'd2;
    localparam logic [2:0]  c_RD_WAIT = 3'd3;
    localparam logic [2:0]  c_RD_RESP = 3'd4;
    localparam int          c_DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [3:0]  c_LAT     = 4'(LATENCY);
    localparam logic [29:0] c_BASE_W  = BASE[31:2];
    localparam logic [1:0]  c_OKAY    = 2'b00;
    localparam logic [1:0]  c_SLVERR  = 2'b10;

    logic [2:0]  r_state;
    logic        r_aw_got;
    logic        r_w_got;
    logic [29:0] r_awaddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [29:0] r_araddr;
    logic [3:0]  r_cnt;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic        r_rvalid;
    logic [1:0]  r_rresp;
    logic [31:0] r_rdata;
    logic [31:0] r_mem [c_DEPTH];

    logic                  w_idle;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_aw_got_nxt;
    logic                  w_w_got_nxt;
    logic [29:0]           w_wr_off;
    logic [29:0]           w_rd_off;
    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic [ADDR_WIDTH-1:0] w_wr_idx;
    logic [ADDR_WIDTH-1:0] w_rd_idx;
    logic                  w_mem_we;
    logic                  w_unused;

    // Byte offset bits are dropped: the master always issues aligned words.
    assign w_unused = ^{awaddr[1:0], araddr[1:0]};

    assign w_idle  = (r_state == c_IDLE);
    assign awready = w_idle && !r_aw_got;
    assign wready  = w_idle && !r_w_got;
    assign arready = w_idle && !r_aw_got && !r_w_got && !awvalid && !wvalid;

    assign w_aw_hs      = awvalid && awready;
    assign w_w_hs       = wvalid && wready;
    assign w_ar_hs      = arvalid && arready;
    assign w_aw_got_nxt = r_aw_got || w_aw_hs;
    assign w_w_got_nxt  = r_w_got || w_w_hs;

    // Word offsets wrap below BASE, so a single upper-bits test covers both ends.
    assign w_wr_off      = r_awaddr - c_BASE_W;
    assign w_rd_off      = r_araddr - c_BASE_W;
    assign w_wr_in_range = (w_wr_off[29:ADDR_WIDTH] == '0);
    assign w_rd_in_range = (w_rd_off[29:ADDR_WIDTH] == '0);
    assign w_wr_idx      = w_wr_off[ADDR_WIDTH-1:0];
    assign w_rd_idx      = w_rd_off[ADDR_WIDTH-1:0];

    assign w_mem_we = (r_state == c_WR_WAIT) && (r_cnt == 4'd0) && w_wr_in_range;

    assign bvalid = r_bvalid;
    assign bresp  = r_bresp;
    assign rvalid = r_rvalid;
    assign rresp  = r_rresp;
    assign rdata  = r_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_araddr <= '0;
            r_cnt    <= '0;
            r_bvalid <= 1'b0;
            r_bresp  <= c_OKAY;
            r_rvalid <= 1'b0;
            r_rresp  <= c_OKAY;
            r_rdata  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_aw_hs) begin
                        r_awaddr <= awaddr[31:2];
                        r_aw_got <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wdata <= wdata;
                        r_wstrb <= wstrb;
                        r_w_got <= 1'b1;
                    end
                    if (w_aw_got_nxt && w_w_got_nxt) begin
                        r_state <= c_WR_WAIT;
                        r_cnt   <= c_LAT;
                    end else if (w_ar_hs) begin
                        r_araddr <= araddr[31:2];
                        r_state  <= c_RD_WAIT;
                        r_cnt    <= c_LAT;
                    end
                end
                c_WR_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_bvalid <= 1'b1;
                        r_bresp  <= w_wr_in_range ? c_OKAY : c_SLVERR;
                        r_state  <= c_WR_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_WR_RESP: begin
                    if (bready) begin
                        r_bvalid <= 1'b0;
                        r_aw_got <= 1'b0;
                        r_w_got  <= 1'b0;
                        r_state  <= c_IDLE;
                    end
                end
                c_RD_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_rvalid <= 1'b1;
                        r_rresp  <= w_rd_in_range ? c_OKAY : c_SLVERR;
                        r_rdata  <= w_rd_in_range ? r_mem[w_rd_idx] : 32'd0;
                        r_state  <= c_RD_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_RD_RESP: begin
                    if (rready) begin
                        r_rvalid <= 1'b0;
                        r_aw_got <= 1'b0;
                        r_w_got  <= 1'b0;
                        r_state  <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Storage is deliberately outside the reset domain so contents survive rst.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (r_wstrb[b]) begin
                    r_mem[w_wr_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire
